// File: rtl/div_pkg.sv
// div_pkg: shared state type, widths and constants for the divider.
// Imported by div_32 and cond_negate.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

  localparam logic [DIV_WIDTH-1:0] DIV_MIN_NEG = 32'h8000_0000;
  localparam logic [DIV_WIDTH-1:0] DIV_NEG_ONE = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Only signed case whose quotient does not fit in WIDTH bits.
  function automatic logic is_overflow(
    input logic [DIV_WIDTH-1:0] a,
    input logic [DIV_WIDTH-1:0] b
  );
    return (a == DIV_MIN_NEG) && (b == DIV_NEG_ONE);
  endfunction

endpackage

// File: rtl/div_32_cond_negate.sv
// cond_negate: two's-complement negate when neg is set.
// Used for operand magnitudes and final sign application.
module cond_negate
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] din,
  input  logic             neg,
  output logic [WIDTH-1:0] dout
);

  assign dout = neg ? (~din + WIDTH'(1)) : din;

endmodule

// File: rtl/div_32.sv
// div_32: iterative signed restoring divider, one bit per clock.
// DIV_FASTZERO_EN: finish divide-by-zero at start, skipping RUN.
module div_32
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  div_state_t state;

  logic [DIV_CNT_W-1:0] cnt;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;
  logic q_sign;
  logic r_sign;
  logic dz;
  logic ovf;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] quo_nx;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH:0]   shf;
  logic [WIDTH:0]   trial;
  logic take;
  logic last;
  logic fin;
  logic b_zero;
  logic b_ovf;
  logic fast;

  cond_negate #(.WIDTH(WIDTH)) u_neg_a (
    .din  (data_operandA),
    .neg  (data_operandA[WIDTH-1]),
    .dout (a_mag)
  );

  cond_negate #(.WIDTH(WIDTH)) u_neg_b (
    .din  (data_operandB),
    .neg  (data_operandB[WIDTH-1]),
    .dout (b_mag)
  );

  cond_negate #(.WIDTH(WIDTH)) u_neg_q (
    .din  (quo_nx),
    .neg  (q_sign),
    .dout (q_fix)
  );

  cond_negate #(.WIDTH(WIDTH)) u_neg_r (
    .din  (rem_nx),
    .neg  (r_sign),
    .dout (r_fix)
  );

  // Partial remainder never exceeds WIDTH bits for nonzero divisors,
  // so the top bit of the WIDTH+1 subtract is a clean borrow.
  assign shf    = {rem, quo[WIDTH-1]};
  assign trial  = shf - {1'b0, dvs};
  assign take   = ~trial[WIDTH];
  assign rem_nx = take ? trial[WIDTH-1:0] : shf[WIDTH-1:0];
  assign quo_nx = {quo[WIDTH-2:0], take};

  assign last   = (cnt == DIV_CNT_W'(WIDTH - 1));
  assign fin    = !ctrl_div && (state == RUN) && last;
  assign b_zero = (data_operandB == '0);
  assign b_ovf  = is_overflow(data_operandA, data_operandB);
  assign busy   = (state == RUN);

`ifdef DIV_FASTZERO_EN
  assign fast = b_zero;
`else
  assign fast = 1'b0;
`endif

  // State, counter and datapath; a start in any state reloads.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      quo    <= '0;
      rem    <= '0;
      dvs    <= '0;
      q_sign <= 1'b0;
      r_sign <= 1'b0;
      dz     <= 1'b0;
      ovf    <= 1'b0;
    end else if (ctrl_div) begin
      state  <= fast ? DONE : RUN;
      cnt    <= '0;
      quo    <= a_mag;
      rem    <= '0;
      dvs    <= b_mag;
      q_sign <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      r_sign <= data_operandA[WIDTH-1];
      dz     <= b_zero;
      ovf    <= b_ovf;
    end else begin
      unique case (state)
        RUN: begin
          quo <= quo_nx;
          rem <= rem_nx;
          cnt <= cnt + DIV_CNT_W'(1);
          if (last) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Result registers load as DONE is entered, so they are
  // valid in the ready cycle and hold until the next one.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_result    <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_div && fast) begin
        data_result    <= '0;
        data_remainder <= '0;
        data_exception <= 1'b1;
        data_resultRDY <= 1'b1;
      end else if (fin) begin
        data_resultRDY <= 1'b1;
        unique case (1'b1)
          dz: begin
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b1;
          end
          ovf: begin
            data_result    <= DIV_MIN_NEG;
            data_remainder <= '0;
            data_exception <= 1'b1;
          end
          default: begin
            data_result    <= q_fix;
            data_remainder <= r_fix;
            data_exception <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
